// File: rtl/wbuf_pkg.sv
// Shared types and constants for the weight buffer controller.
// Holds the FSM state enum, skid FIFO sizing and a counter-width helper.
package wbuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_DRAIN
    } wbuf_state_e;

    // Width of a counter that must hold values 0..n-1 (at least 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DW_DEF     = 128;
    localparam int IW_DEF     = 32;
    localparam int PACK_DEF   = DW_DEF / IW_DEF;
    localparam int PACK_W     = cnt_w(PACK_DEF);
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/weight_buf_ctrl_skid_fifo.sv
// wbuf_skid_fifo: 2-entry DW-bit FIFO buffering RAM read data for the PE array.
// Ports: clk, rst, i_push/i_data, i_pop, o_count, o_valid, o_head.
module wbuf_skid_fifo
    import wbuf_pkg::*;
#(
    parameter int DW = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [DW-1:0]      i_data,
    input  logic               i_pop,
    output logic [SKID_CW-1:0] o_count,
    output logic               o_valid,
    output logic [DW-1:0]      o_head
);

    logic [DW-1:0]      r_mem [SKID_DEPTH];
    logic               r_rd;
    logic               r_wr;
    logic [SKID_CW-1:0] r_cnt;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_push && (r_cnt < SKID_CW'(SKID_DEPTH));
    assign w_pop  = i_pop && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_count = r_cnt;
    assign o_valid = (r_cnt != '0);
    assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/weight_buf_ctrl.sv
// weight_buf_ctrl: packs IW-bit DMA beats into DW-bit RAM words (LOAD) and
// streams RAM words to the PE array through a 2-entry skid FIFO (READ/DRAIN).
// Ports: clk, rst (sync, active-high); i_ld_start/i_rd_start/i_base_addr/i_len
// start a job; i_in_valid/i_in_data/o_in_ready DMA side; o_w_valid/o_w_data/
// i_w_ready PE side; o_ld_done/o_rd_done/o_busy status; o_ram_* and
// i_ram_rdata drive the single-port weight RAM.
// Option: WBUF_PERF_CNT_EN adds o_stall_cnt (saturating stall cycle counter).
module weight_buf_ctrl
    import wbuf_pkg::*;
#(
    parameter int DW      = 128,
    parameter int IW      = 32,
    parameter int AW      = 4,
    parameter int DEPTH   = 16,
    parameter int N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ld_start,
    input  logic          i_rd_start,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW:0]   i_len,
    input  logic          i_in_valid,
    input  logic [IW-1:0] i_in_data,
    output logic          o_in_ready,
    output logic          o_w_valid,
    output logic [DW-1:0] o_w_data,
    input  logic          i_w_ready,
    output logic          o_ld_done,
    output logic          o_rd_done,
    output logic          o_busy,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_we,
    output logic          o_ram_cs,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
`ifdef WBUF_PERF_CNT_EN
    ,
    output logic [31:0]   o_stall_cnt
`endif
);

    localparam int PACK = DW / IW;
    localparam int PCW  = cnt_w(PACK);

    wbuf_state_e        r_state;
    wbuf_state_e        w_next;
    logic [AW-1:0]      r_cur;
    logic [AW:0]        r_rem;
    logic [PCW-1:0]     r_pcnt;
    logic [DW-1:0]      r_pack;
    logic [N_DELAY-1:0] r_vpipe;
    logic               r_ld_done;
    logic               r_rd_done;

    logic [DW-1:0]      w_packed;
    logic [AW-1:0]      w_cur_nxt;
    logic               w_accept;
    logic               w_last_beat;
    logic               w_write;
    logic               w_issue;
    logic               w_credit;
    logic               w_push;
    logic               w_pop;
    logic               w_fvalid;
    logic [DW-1:0]      w_fhead;
    logic [SKID_CW-1:0] w_cnt;
    logic [SKID_CW-1:0] w_infl;
    logic [2:0]         w_cnt_nxt;
    logic [2:0]         w_infl_nxt;

    // First beat ends up in the low lane after PACK right-shifts.
    if (PACK > 1) begin : g_pack
        assign w_packed = {i_in_data, r_pack[DW-1:IW]};
    end else begin : g_nopack
        assign w_packed = i_in_data;
    end

    assign w_cur_nxt   = (r_cur == AW'(DEPTH - 1)) ? '0 : r_cur + 1'b1;
    assign w_accept    = (r_state == ST_LOAD) && !rst && i_in_valid;
    assign w_last_beat = (r_pcnt == PCW'(PACK - 1));
    assign w_write     = w_accept && w_last_beat;
    assign w_push      = r_vpipe[N_DELAY-1];
    assign w_pop       = o_w_valid && i_w_ready;

    always_comb begin
        w_infl = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            w_infl = w_infl + SKID_CW'(r_vpipe[i]);
        end
    end

    // A word leaving the FIFO this cycle frees its slot for a new issue,
    // which keeps the stream at one word per cycle.
    assign w_credit = ({1'b0, w_infl} + {1'b0, w_cnt})
                      < (3'd2 + {2'b0, w_pop});
    assign w_issue  = (r_state == ST_READ) && !rst && w_credit;

    assign w_cnt_nxt  = {1'b0, w_cnt} + {2'b0, w_push} - {2'b0, w_pop};
    assign w_infl_nxt = {1'b0, w_infl} - {2'b0, w_push};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_ld_start) begin
                    if (i_len != '0) w_next = ST_LOAD;
                end else if (i_rd_start) begin
                    if (i_len != '0) w_next = ST_READ;
                end
            end
            ST_LOAD: begin
                if (w_write && r_rem == (AW+1)'(1)) w_next = ST_IDLE;
            end
            ST_READ: begin
                if (w_issue && r_rem == (AW+1)'(1)) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_cnt_nxt == '0 && w_infl_nxt == '0) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cur     <= '0;
            r_rem     <= '0;
            r_pcnt    <= '0;
            r_pack    <= '0;
            r_vpipe   <= '0;
            r_ld_done <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ld_done  <= 1'b0;
            r_rd_done  <= 1'b0;
            r_vpipe[0] <= w_issue;
            for (int i = 1; i < N_DELAY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            if (r_state == ST_IDLE) begin
                if (i_ld_start) begin
                    r_cur     <= i_base_addr;
                    r_rem     <= i_len;
                    r_pcnt    <= '0;
                    r_ld_done <= (i_len == '0);
                end else if (i_rd_start) begin
                    r_cur     <= i_base_addr;
                    r_rem     <= i_len;
                    r_rd_done <= (i_len == '0);
                end
            end
            if (w_accept) begin
                r_pack <= w_packed;
                r_pcnt <= w_last_beat ? '0 : r_pcnt + 1'b1;
            end
            if (w_write || w_issue) begin
                r_cur <= w_cur_nxt;
                r_rem <= r_rem - 1'b1;
            end
            if (w_write && r_rem == (AW+1)'(1)) begin
                r_ld_done <= 1'b1;
            end
            if (r_state == ST_DRAIN && w_next == ST_IDLE) begin
                r_rd_done <= 1'b1;
            end
        end
    end

    wbuf_skid_fifo #(
        .DW (DW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (i_ram_rdata),
        .i_pop   (w_pop),
        .o_count (w_cnt),
        .o_valid (w_fvalid),
        .o_head  (w_fhead)
    );

    assign o_in_ready  = (r_state == ST_LOAD) && !rst;
    assign o_w_valid   = w_fvalid && !rst;
    assign o_w_data    = w_fhead;
    assign o_ld_done   = r_ld_done;
    assign o_rd_done   = r_rd_done;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_ram_cs    = w_write || w_issue;
    assign o_ram_we    = w_write;
    assign o_ram_addr  = (w_write || w_issue) ? r_cur : '0;
    assign o_ram_wdata = w_write ? w_packed : '0;

`ifdef WBUF_PERF_CNT_EN
    logic [31:0] r_stall;
    logic        w_stall;

    assign w_stall = (o_w_valid && !i_w_ready)
                  || (r_state == ST_LOAD && i_in_valid && !o_in_ready);

    always_ff @(posedge clk) begin
        if (rst || i_ld_start || i_rd_start) begin
            r_stall <= '0;
        end else if (w_stall && r_stall != '1) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_weight_buf_ctrl.sv
// Directed bench for weight_buf_ctrl with a 1-cycle-latency RAM model.
// Inputs change #1 after posedge; outputs are compared on the negedge.
module tb_weight_buf_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld_start;
    logic         rd_start;
    logic [3:0]   base_addr;
    logic [4:0]   len;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         w_valid;
    logic [127:0] w_data;
    logic         w_ready;
    logic         ld_done;
    logic         rd_done;
    logic         busy;
    logic [3:0]   ram_addr;
    logic         ram_we;
    logic         ram_cs;
    logic [127:0] ram_wdata;
    logic [127:0] ram_rdata;
`ifdef WBUF_PERF_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    weight_buf_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_ld_start  (ld_start),
        .i_rd_start  (rd_start),
        .i_base_addr (base_addr),
        .i_len       (len),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_w_valid   (w_valid),
        .o_w_data    (w_data),
        .i_w_ready   (w_ready),
        .o_ld_done   (ld_done),
        .o_rd_done   (rd_done),
        .o_busy      (busy),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_cs    (ram_cs),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
`ifdef WBUF_PERF_CNT_EN
        ,
        .o_stall_cnt (stall_cnt)
`endif
    );

    // RAM model with a bench-side preload port.
    logic [127:0] mem [16];
    logic         pre_we = 1'b0;
    logic [3:0]   pre_a  = '0;
    logic [127:0] pre_d  = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Bus monitor.
    int           cs_cnt = 0;
    int           wr_cnt = 0;
    int           iss = 0;
    int           acc = 0;
    int           max_out = 0;
    int           hold_viol = 0;
    logic [3:0]   last_wa = '0;
    logic [127:0] last_wd = '0;
    logic [127:0] acc_q [$];
    logic         hold_prev = 1'b0;
    logic [127:0] prev_d = '0;

    always @(negedge clk) begin
        if (ram_cs) cs_cnt++;
        if (ram_cs && ram_we) begin
            wr_cnt++;
            last_wa = ram_addr;
            last_wd = ram_wdata;
        end
        if (ram_cs && !ram_we) iss++;
        if (w_valid && w_ready) begin
            acc++;
            acc_q.push_back(w_data);
        end
        if (iss - acc > max_out) max_out = iss - acc;
        if (hold_prev && (!w_valid || w_data !== prev_d)) hold_viol++;
        hold_prev = w_valid && !w_ready;
        prev_d    = w_data;
    end

    function automatic logic [127:0] pat(input int a);
        return {32'(32'hD000_0000 + a), 32'(32'hC000_0000 + a),
                32'(32'hB000_0000 + a), 32'(32'hA000_0000 + a)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Cycle table for the stall-free read (cycles 1..6 after rd_start).
    int   rd_ea  [6] = '{14, 15, 0, 1, 0, 0};
    bit   rd_ecs [6] = '{1, 1, 1, 1, 0, 0};
    bit   rd_ewv [6] = '{0, 0, 1, 1, 1, 1};
    int   rd_ewd [6] = '{0, 0, 14, 15, 0, 1};

    initial begin
        bit rdy_all;
        bit done;
        int s;
        int c0;
        int w0;
        int i0;

        rst = 1'b1; ld_start = 0; rd_start = 0; base_addr = '0; len = '0;
        in_valid = 0; in_data = '0; w_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_hold", {busy, in_ready, ram_cs}, '0);
        step;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", {busy, in_ready, w_valid, ld_done, rd_done,
                           ram_cs, ram_we}, '0);
        chk("reset_addr", {ram_addr, ram_wdata}, '0);
`ifdef WBUF_PERF_CNT_EN
        chk("reset_stall", stall_cnt, '0);
`endif
        step;

        for (int a = 0; a < 16; a++) begin
            pre_we = 1'b1; pre_a = 4'(a); pre_d = pat(a);
            step;
        end
        pre_we = 1'b0;
        step;

        // Load: 2 words at 3, beats 0..7 back-to-back.
        ld_start = 1; base_addr = 4'd3; len = 5'd2;
        step;
        ld_start = 0;
        rdy_all = 1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1; in_data = 32'(k);
            @(negedge clk);
            if (!in_ready) rdy_all = 0;
            if (k == 3) begin
                chk("ld_w0_ctl", {ram_cs, ram_we, ram_addr}, {2'b11, 4'd3});
                chk("ld_w0_data", ram_wdata,
                    128'h00000003_00000002_00000001_00000000);
            end
            if (k == 7) begin
                chk("ld_w1_ctl", {ram_cs, ram_we, ram_addr}, {2'b11, 4'd4});
                chk("ld_w1_data", ram_wdata,
                    128'h00000007_00000006_00000005_00000004);
                chk("ld_done_early", ld_done, 0);
            end
            step;
        end
        in_valid = 0;
        chk("ld_ready_steady", rdy_all, 1);
        @(negedge clk);
        chk("ld_done", {ld_done, busy}, 2'b10);
        step;
        @(negedge clk);
        chk("ld_done_pulse", ld_done, 0);
        step;

        // Read 4 words from 14 with wrap, no stalls.
        w_ready = 1;
        s = acc_q.size();
        rd_start = 1; base_addr = 4'd14; len = 5'd4;
        step;
        rd_start = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rd_cs_c%0d", c + 1), ram_cs, rd_ecs[c]);
            if (rd_ecs[c]) chk($sformatf("rd_addr_c%0d", c + 1),
                               {ram_we, ram_addr}, {1'b0, 4'(rd_ea[c])});
            chk($sformatf("rd_wv_c%0d", c + 1), w_valid, rd_ewv[c]);
            if (rd_ewv[c]) chk($sformatf("rd_wd_c%0d", c + 1),
                               w_data, pat(rd_ewd[c]));
            step;
        end
        @(negedge clk);
        chk("rd_done", {rd_done, busy}, 2'b10);
        chk("rd_count", acc_q.size() - s, 4);
        step;

        // Read 6 words from 5 with a 5-cycle stall.
        s = acc_q.size();
        rd_start = 1; base_addr = 4'd5; len = 5'd6;
        step;
        rd_start = 0;
        repeat (3) step;
        w_ready = 0;
        repeat (4) step;
        @(negedge clk);
        chk("bp_head", {w_valid, w_data}, {1'b1, pat(6)});
        step;
        w_ready = 1;
`ifdef WBUF_PERF_CNT_EN
        @(negedge clk);
        chk("bp_stall_cnt", stall_cnt, 5);
`endif
        done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_done) begin
                done = 1;
                break;
            end
        end
        step;
        chk("bp_done_seen", done, 1);
        chk("bp_count", acc_q.size() - s, 6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("bp_word%0d", j), acc_q[s + j], pat(5 + j));
        end
        chk("bp_hold", hold_viol, 0);
        chk("bp_outstanding", max_out <= 2, 1);
`ifdef WBUF_PERF_CNT_EN
        chk("bp_stall_final", stall_cnt, 5);
`endif

        // len == 0 load and read.
        c0 = cs_cnt;
        ld_start = 1; base_addr = 4'd7; len = 5'd0;
        step;
        ld_start = 0;
        @(negedge clk);
        chk("len0_ld", {ld_done, busy}, 2'b10);
        step;
        rd_start = 1;
        step;
        rd_start = 0;
        @(negedge clk);
        chk("len0_rd", {rd_done, ld_done, busy}, 3'b100);
        step;
        chk("len0_no_cs", cs_cnt - c0, 0);

        // Abort a load after 2 of 4 beats.
        ld_start = 1; base_addr = 4'd9; len = 5'd1;
        step;
        ld_start = 0;
        in_valid = 1; in_data = 32'hAA;
        step;
        in_data = 32'hBB;
        step;
        rst = 1; in_data = 32'hCC;
        @(negedge clk);
        chk("abort_rst_cyc", {ram_cs, in_ready}, 2'b00);
        step;
        rst = 0; in_valid = 0;
        @(negedge clk);
        chk("abort_idle", {busy, in_ready}, 2'b00);
        step;
        w0 = wr_cnt;
        ld_start = 1; base_addr = 4'd9; len = 5'd1;
        step;
        ld_start = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_data = 32'(32'h10 + k);
            step;
        end
        in_valid = 0;
        @(negedge clk);
        chk("abort_reload_done", ld_done, 1);
        chk("abort_reload_wr", {32'(wr_cnt - w0), last_wa}, {32'd1, 4'd9});
        chk("abort_reload_data", last_wd,
            128'h00000013_00000012_00000011_00000010);
        step;

        // Collisions.
        i0 = iss;
        ld_start = 1; rd_start = 1; base_addr = 4'd2; len = 5'd1;
        step;
        ld_start = 0; rd_start = 0;
        @(negedge clk);
        chk("col_load_taken", {in_ready, busy}, 2'b11);
        rd_start = 1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_data = 32'(32'h21 + k);
            step;
            rd_start = 0;
        end
        in_valid = 0;
        @(negedge clk);
        chk("col_ld_done", {ld_done, busy}, 2'b10);
        step;
        @(negedge clk);
        chk("col_rd_ignored", {busy, 32'(iss - i0)}, '0);
        step;
        w0 = wr_cnt;
        s = acc_q.size();
        w_ready = 1;
        rd_start = 1; base_addr = 4'd2; len = 5'd1;
        in_valid = 1; in_data = 32'hEE;
        step;
        rd_start = 0;
        @(negedge clk);
        chk("col_rd_no_ready", {in_ready, busy}, 2'b01);
        done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_done) begin
                done = 1;
                break;
            end
        end
        step;
        in_valid = 0;
        chk("col_rd_done", done, 1);
        chk("col_rd_no_wr", wr_cnt - w0, 0);
        chk("col_rd_count", acc_q.size() - s, 1);
        chk("col_rd_word", acc_q[s],
            128'h00000024_00000023_00000022_00000021);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
